// File: rtl/e_stage_reg.sv
`default_nettype none
// ============================================================================
// e_stage_reg : Y86-64 decode-to-execute pipeline register with stall/bubble
//               control and saturating stall/bubble event counters.
// Revision    : 1.0
// ============================================================================
module e_stage_reg #(
  parameter int         WORD_W         = 64,
  parameter int         NUM_VALS       = 3,
  parameter int         CNT_W          = 16,
  parameter logic [3:0] BUBBLE_ICODE   = 4'h1,
  parameter logic [3:0] STAT_AOK       = 4'h1,
  parameter logic [3:0] REG_NONE       = 4'hF,
  parameter int         ZERO_ON_BUBBLE = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       E_stall,
  input  logic                       E_bubble,
  input  logic                       cnt_clr,
  input  logic [3:0]                 d_icode,
  input  logic [3:0]                 d_ifun,
  input  logic [3:0]                 d_stat,
  input  logic [3:0]                 d_dstE,
  input  logic [3:0]                 d_dstM,
  input  logic [NUM_VALS*WORD_W-1:0] d_vals,
  output logic [3:0]                 E_icode,
  output logic [3:0]                 E_ifun,
  output logic [3:0]                 E_stat,
  output logic [3:0]                 E_dstE,
  output logic [3:0]                 E_dstM,
  output logic [NUM_VALS*WORD_W-1:0] E_vals,
  output logic                       E_valid,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           bubble_cnt,
  output logic                       ctl_conflict
);

  localparam int               c_VALS_W  = NUM_VALS * WORD_W;
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  logic [3:0]          r_icode;
  logic [3:0]          r_ifun;
  logic [3:0]          r_stat;
  logic [3:0]          r_dstE;
  logic [3:0]          r_dstM;
  logic [c_VALS_W-1:0] r_vals;
  logic                r_valid;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_bubble_cnt;
  logic                r_conflict;

  logic [c_VALS_W-1:0] w_bubble_vals;
  logic                w_stall_only;

  assign w_stall_only = E_stall & ~E_bubble;

  // Value fields on a bubble either clear or keep the previous operands.
  generate
    if (ZERO_ON_BUBBLE != 0) begin : g_bubble_zero
      assign w_bubble_vals = '0;
    end else begin : g_bubble_hold
      assign w_bubble_vals = r_vals;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_icode      <= BUBBLE_ICODE;
      r_ifun       <= 4'h0;
      r_stat       <= STAT_AOK;
      r_dstE       <= REG_NONE;
      r_dstM       <= REG_NONE;
      r_vals       <= '0;
      r_valid      <= 1'b0;
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
      r_conflict   <= 1'b0;
    end else begin
      // Bubble outranks stall; a stall simply leaves every field untouched.
      if (E_bubble) begin
        r_icode <= BUBBLE_ICODE;
        r_ifun  <= 4'h0;
        r_stat  <= STAT_AOK;
        r_dstE  <= REG_NONE;
        r_dstM  <= REG_NONE;
        r_vals  <= w_bubble_vals;
        r_valid <= 1'b0;
      end else if (!E_stall) begin
        r_icode <= d_icode;
        r_ifun  <= d_ifun;
        r_stat  <= d_stat;
        r_dstE  <= d_dstE;
        r_dstM  <= d_dstM;
        r_vals  <= d_vals;
        r_valid <= 1'b1;
      end

      if (cnt_clr) begin
        r_stall_cnt  <= '0;
        r_bubble_cnt <= '0;
        r_conflict   <= 1'b0;
      end else begin
        if (E_bubble && (r_bubble_cnt != c_CNT_MAX)) begin
          r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
        if (w_stall_only && (r_stall_cnt != c_CNT_MAX)) begin
          r_stall_cnt <= r_stall_cnt + 1'b1;
        end
        if (E_stall && E_bubble) begin
          r_conflict <= 1'b1;
        end
      end
    end
  end

  assign E_icode      = r_icode;
  assign E_ifun       = r_ifun;
  assign E_stat       = r_stat;
  assign E_dstE       = r_dstE;
  assign E_dstM       = r_dstM;
  assign E_vals       = r_vals;
  assign E_valid      = r_valid;
  assign stall_cnt    = r_stall_cnt;
  assign bubble_cnt   = r_bubble_cnt;
  assign ctl_conflict = r_conflict;

endmodule
`default_nettype wire

// File: tb/tb_e_stage_reg.sv
`default_nettype none
// ============================================================================
// tb_e_stage_reg : three configurations of e_stage_reg driven in lockstep and
//                  compared against a behavioural stage model.
// Revision       : 1.0
// ============================================================================
module tb_e_stage_reg;

  logic         clk;
  logic         clk_run;
  logic         rst_n;
  logic         E_stall, E_bubble, cnt_clr;
  logic [3:0]   d_icode, d_ifun, d_stat, d_dstE, d_dstM;
  logic [191:0] d_bus;

  // Instance A: defaults (64b x 3, CNT_W=16, zero on bubble)
  logic [3:0]   a_icode, a_ifun, a_stat, a_dstE, a_dstM;
  logic [191:0] a_vals;
  logic         a_valid, a_conf;
  logic [15:0]  a_sc, a_bc;
  // Instance B: 8b x 8, CNT_W=4, hold on bubble
  logic [3:0]   b_icode, b_ifun, b_stat, b_dstE, b_dstM;
  logic [63:0]  b_vals;
  logic         b_valid, b_conf;
  logic [3:0]   b_sc, b_bc;
  // Instance C: 8b x 1
  logic [3:0]   c_icode, c_ifun, c_stat, c_dstE, c_dstM;
  logic [7:0]   c_vals;
  logic         c_valid, c_conf;
  logic [15:0]  c_sc, c_bc;

  e_stage_reg u_a (
    .clk(clk), .rst_n(rst_n), .E_stall(E_stall), .E_bubble(E_bubble), .cnt_clr(cnt_clr),
    .d_icode(d_icode), .d_ifun(d_ifun), .d_stat(d_stat), .d_dstE(d_dstE), .d_dstM(d_dstM),
    .d_vals(d_bus),
    .E_icode(a_icode), .E_ifun(a_ifun), .E_stat(a_stat), .E_dstE(a_dstE), .E_dstM(a_dstM),
    .E_vals(a_vals), .E_valid(a_valid), .stall_cnt(a_sc), .bubble_cnt(a_bc),
    .ctl_conflict(a_conf)
  );

  e_stage_reg #(.WORD_W(8), .NUM_VALS(8), .CNT_W(4), .ZERO_ON_BUBBLE(0)) u_b (
    .clk(clk), .rst_n(rst_n), .E_stall(E_stall), .E_bubble(E_bubble), .cnt_clr(cnt_clr),
    .d_icode(d_icode), .d_ifun(d_ifun), .d_stat(d_stat), .d_dstE(d_dstE), .d_dstM(d_dstM),
    .d_vals(d_bus[63:0]),
    .E_icode(b_icode), .E_ifun(b_ifun), .E_stat(b_stat), .E_dstE(b_dstE), .E_dstM(b_dstM),
    .E_vals(b_vals), .E_valid(b_valid), .stall_cnt(b_sc), .bubble_cnt(b_bc),
    .ctl_conflict(b_conf)
  );

  e_stage_reg #(.WORD_W(8), .NUM_VALS(1)) u_c (
    .clk(clk), .rst_n(rst_n), .E_stall(E_stall), .E_bubble(E_bubble), .cnt_clr(cnt_clr),
    .d_icode(d_icode), .d_ifun(d_ifun), .d_stat(d_stat), .d_dstE(d_dstE), .d_dstM(d_dstM),
    .d_vals(d_bus[7:0]),
    .E_icode(c_icode), .E_ifun(c_ifun), .E_stat(c_stat), .E_dstE(c_dstE), .E_dstM(c_dstM),
    .E_vals(c_vals), .E_valid(c_valid), .stall_cnt(c_sc), .bubble_cnt(c_bc),
    .ctl_conflict(c_conf)
  );

  typedef struct {
    logic [3:0]   icode, ifun, stat, dste, dstm;
    logic         valid, conf;
    logic [191:0] vals;
    int           sc, bc;
  } model_t;

  model_t       m [3];
  int           cnt_w [3] = '{16, 4, 16};
  bit           zob [3]   = '{1'b1, 1'b0, 1'b1};
  logic [191:0] vmask [3];

  int n_pass  = 0;
  int n_total = 0;

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_run) clk = ~clk;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic model_t reset_model();
    model_t r;
    r.icode = 4'h1; r.ifun = 4'h0; r.stat = 4'h1; r.dste = 4'hF; r.dstm = 4'hF;
    r.valid = 1'b0; r.conf = 1'b0; r.vals = '0; r.sc = 0; r.bc = 0;
    return r;
  endfunction

  // One clock edge of the stage as described behaviourally.
  function automatic model_t nxt(model_t s, int k);
    model_t r = s;
    int cmax = (1 << cnt_w[k]) - 1;
    if (E_bubble) begin
      r.icode = 4'h1; r.ifun = 4'h0; r.stat = 4'h1; r.dste = 4'hF; r.dstm = 4'hF;
      r.valid = 1'b0;
      if (zob[k]) r.vals = '0;
    end else if (!E_stall) begin
      r.icode = d_icode; r.ifun = d_ifun; r.stat = d_stat; r.dste = d_dstE; r.dstm = d_dstM;
      r.valid = 1'b1;
      r.vals  = d_bus & vmask[k];
    end
    if (cnt_clr) begin
      r.sc = 0; r.bc = 0; r.conf = 1'b0;
    end else begin
      if (E_bubble) r.bc = (s.bc < cmax) ? s.bc + 1 : cmax;
      if (E_stall && !E_bubble) r.sc = (s.sc < cmax) ? s.sc + 1 : cmax;
      if (E_stall && E_bubble) r.conf = 1'b1;
    end
    return r;
  endfunction

  task automatic chk(string tag, logic [191:0] obs, logic [191:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_inst(string tag, int k, logic [3:0] icode, ifun, stat, dste, dstm,
                            logic valid, conf, logic [191:0] vals, logic [31:0] sc, bc);
    chk({tag, "/ctl"}, 192'({icode, ifun, stat, dste, dstm, valid, conf}),
        192'({m[k].icode, m[k].ifun, m[k].stat, m[k].dste, m[k].dstm, m[k].valid, m[k].conf}));
    chk({tag, "/vals"}, vals, m[k].vals);
    chk({tag, "/stall_cnt"}, 192'(sc), 192'(m[k].sc));
    chk({tag, "/bubble_cnt"}, 192'(bc), 192'(m[k].bc));
  endtask

  task automatic check_all(string tag);
    check_inst({tag, "/A"}, 0, a_icode, a_ifun, a_stat, a_dstE, a_dstM, a_valid, a_conf,
               a_vals, 32'(a_sc), 32'(a_bc));
    check_inst({tag, "/B"}, 1, b_icode, b_ifun, b_stat, b_dstE, b_dstM, b_valid, b_conf,
               192'(b_vals), 32'(b_sc), 32'(b_bc));
    check_inst({tag, "/C"}, 2, c_icode, c_ifun, c_stat, c_dstE, c_dstM, c_valid, c_conf,
               192'(c_vals), 32'(c_sc), 32'(c_bc));
  endtask

  task automatic ctl(logic s, logic b, logic c);
    E_stall = s; E_bubble = b; cnt_clr = c;
  endtask

  task automatic dset(logic [3:0] ic, fn, st, de, dm, logic [191:0] v);
    d_icode = ic; d_ifun = fn; d_stat = st; d_dstE = de; d_dstM = dm; d_bus = v;
  endtask

  task automatic cycle(string tag);
    @(posedge clk);
    for (int k = 0; k < 3; k++) m[k] = nxt(m[k], k);
    @(negedge clk);
    check_all(tag);
  endtask

  logic [191:0] rv;

  initial begin
    vmask[0] = '1;
    vmask[1] = {128'b0, {64{1'b1}}};
    vmask[2] = {184'b0, 8'hFF};
    clk_run = 1'b0;
    rst_n = 1'b1;
    ctl(1'b0, 1'b0, 1'b0);
    dset(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, '0);

    // Asynchronous reset with the clock stopped
    #3 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) m[k] = reset_model();
    check_all("reset_async");
    clk_run = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Load: valC=0x10, valB=0x5, valA=0x3 (B/C see the low byte slices)
    dset(4'h6, 4'h0, 4'h1, 4'h3, 4'hF, {64'h10, 64'h5, 64'h3});
    cycle("load1");
    chk("load1/A/vals_const", a_vals, {64'h10, 64'h5, 64'h3});
    chk("load1/A/valid_const", 192'(a_valid), 192'(1));

    // Stall 3 cycles while inputs change
    ctl(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      dset(4'(i + 2), 4'(i), 4'h2, 4'(i), 4'(i + 1), {3{64'hDEAD_0000 + 64'(i)}});
      cycle("stall3");
    end
    chk("stall3/A/cnt_const", 192'(a_sc), 192'(3));
    chk("stall3/A/icode_const", 192'(a_icode), 192'(6));

    // Bubble over a valid instruction
    ctl(1'b0, 1'b0, 1'b0);
    dset(4'h3, 4'h0, 4'h1, 4'h2, 4'hF, {64'hAA, 64'hBB, 64'hC3C3_5A5A_1234_5678});
    cycle("load2");
    ctl(1'b0, 1'b1, 1'b0);
    cycle("bubble");
    chk("bubble/B/vals_held", 192'(b_vals), 192'(64'hC3C3_5A5A_1234_5678));
    chk("bubble/A/vals_zero", a_vals, '0);

    // Conflict then clear
    ctl(1'b0, 1'b0, 1'b0);
    cycle("load3");
    ctl(1'b1, 1'b1, 1'b0);
    cycle("conflict");
    chk("conflict/A/flag_const", 192'(a_conf), 192'(1));
    ctl(1'b0, 1'b0, 1'b1);
    cycle("cnt_clr");

    // Saturation: 20 stalls, then clear during stall
    ctl(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle("sat_stall");
    chk("sat/B/cnt_const", 192'(b_sc), 192'(15));
    chk("sat/A/cnt_const", 192'(a_sc), 192'(20));
    ctl(1'b1, 1'b0, 1'b1);
    cycle("sat_clr");
    ctl(1'b1, 1'b0, 1'b0);
    cycle("sat_after_clr");
    chk("sat_after_clr/B/cnt_const", 192'(b_sc), 192'(1));

    // Width sweep: 0xA5 and walking ones across field boundaries
    ctl(1'b0, 1'b0, 1'b0);
    dset(4'h2, 4'h0, 4'h1, 4'h1, 4'hF, 192'hA5);
    cycle("a5");
    chk("a5/C/vals_const", 192'(c_vals), 192'(8'hA5));
    for (int i = 0; i < 192; i += 3) begin
      rv = '0;
      rv[i] = 1'b1;
      dset(4'h2, 4'h0, 4'h1, 4'h1, 4'hF, rv);
      cycle("walk1");
    end

    // Reset in the middle of a stall, clock stopped low
    ctl(1'b1, 1'b0, 1'b0);
    cycle("pre_rst_stall");
    clk_run = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) m[k] = reset_model();
    check_all("reset_mid_stall");
    #2 rst_n = 1'b1;
    clk_run = 1'b1;
    ctl(1'b0, 1'b0, 1'b0);
    dset(4'h7, 4'h1, 4'h1, 4'hF, 4'h4, {64'h1, 64'h2, 64'h3});
    cycle("post_rst_load");

    // Randomised phase
    for (int i = 0; i < 400; i++) begin
      ctl(($urandom % 4) == 0, ($urandom % 5) == 0, ($urandom % 24) == 0);
      dset(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
           {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
